// File: rtl/raycast_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raycast_pkg
// Brief    : Shared widths and sweep state encoding for the ray-casting blocks.
// Revision : 1.0
// ============================================================================
package raycast_pkg;

    localparam int ANGLE_W    = 12;
    localparam int COORD_W    = 12;
    localparam int ANGLE_FULL = 4096;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/ray_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : ray_timeout_counter
// Brief    : 12-bit wait counter; flags expiry at TIMEOUT_CYCLES-1.
// Revision : 1.0
// ============================================================================
module ray_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_enable,
    output logic [11:0] o_count,
    output logic        o_expired
);

    localparam logic [11:0] c_LAST = 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] r_count;

    // Holds at the terminal value so expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 12'd0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + 12'd1;
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/ray_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : ray_sweep_controller
// Brief    : Issues one wall-finder ray per screen column and presents each
//            result to the column renderer over valid/ready.
// Revision : 1.0
// ============================================================================
module ray_sweep_controller
    import raycast_pkg::*;
#(
    parameter int NUM_COLS       = 128,
    parameter int ANGLE_STEP     = 5,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start_frame,
    input  logic [COORD_W-1:0] i_playerX,
    input  logic [COORD_W-1:0] i_playerY,
    input  logic [ANGLE_W-1:0] i_player_angle,
    output logic [COORD_W-1:0] o_ray_playerX,
    output logic [COORD_W-1:0] o_ray_playerY,
    output logic [ANGLE_W-1:0] o_alpha,
    output logic               o_begin_calc,
    input  logic [COORD_W-1:0] i_wallX,
    input  logic [COORD_W-1:0] i_wallY,
    input  logic               i_wall_found,
    input  logic               i_end_calc,
    output logic               o_col_valid,
    input  logic               i_col_ready,
    output logic [11:0]        o_col_index,
    output logic [COORD_W-1:0] o_col_wallX,
    output logic [COORD_W-1:0] o_col_wallY,
    output logic               o_col_wall_found,
    output logic               o_col_timeout,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam logic [ANGLE_W-1:0] c_ALPHA_OFFSET = ANGLE_W'(((NUM_COLS / 2) * ANGLE_STEP) % ANGLE_FULL);
    localparam logic [ANGLE_W-1:0] c_STEP         = ANGLE_W'(ANGLE_STEP % ANGLE_FULL);
    localparam logic [11:0]        c_LAST_COL     = 12'(NUM_COLS - 1);

    sweep_state_t       r_state;
    sweep_state_t       w_state_nxt;

    logic [COORD_W-1:0] r_ray_playerX;
    logic [COORD_W-1:0] r_ray_playerY;
    logic [ANGLE_W-1:0] r_alpha;
    logic [11:0]        r_col_index;
    logic [COORD_W-1:0] r_col_wallX;
    logic [COORD_W-1:0] r_col_wallY;
    logic               r_col_wall_found;
    logic               r_col_timeout;

    logic [11:0]        w_tmo_count;
    logic               w_tmo_expired;
    logic               w_in_wait;
    logic               w_accept;
    logic               w_expire;
    logic               w_handshake;
    logic               w_last_col;
    logic               w_begin_calc;
    logic               w_col_valid;
    logic               w_busy;
    logic               w_frame_done;

    ray_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == S_ISSUE),
        .i_enable  (w_in_wait),
        .o_count   (w_tmo_count),
        .o_expired (w_tmo_expired)
    );

    // A zero count marks the first WAIT cycle, where a stale done is dropped.
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_accept    = w_in_wait && i_end_calc && (w_tmo_count != 12'd0);
    assign w_expire    = w_in_wait && w_tmo_expired && !w_accept;
    assign w_handshake = (r_state == S_PRESENT) && i_col_ready;
    assign w_last_col  = (r_col_index == c_LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start_frame) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT:    if (w_accept || w_expire) w_state_nxt = S_PRESENT;
            S_PRESENT: if (i_col_ready) w_state_nxt = w_last_col ? S_DONE : S_ISSUE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_begin_calc = 1'b0;
        w_col_valid  = 1'b0;
        w_frame_done = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE:    w_busy       = 1'b0;
            S_ISSUE:   w_begin_calc = 1'b1;
            S_PRESENT: w_col_valid  = 1'b1;
            S_DONE:    w_frame_done = 1'b1;
            default:   w_busy       = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ray_playerX    <= '0;
            r_ray_playerY    <= '0;
            r_alpha          <= '0;
            r_col_index      <= '0;
            r_col_wallX      <= '0;
            r_col_wallY      <= '0;
            r_col_wall_found <= 1'b0;
            r_col_timeout    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start_frame) begin
                r_ray_playerX <= i_playerX;
                r_ray_playerY <= i_playerY;
                r_alpha       <= i_player_angle - c_ALPHA_OFFSET;
                r_col_index   <= '0;
            end
            if (w_accept) begin
                r_col_wallX      <= i_wallX;
                r_col_wallY      <= i_wallY;
                r_col_wall_found <= i_wall_found;
                r_col_timeout    <= 1'b0;
            end else if (w_expire) begin
                r_col_wallX      <= '0;
                r_col_wallY      <= '0;
                r_col_wall_found <= 1'b0;
                r_col_timeout    <= 1'b1;
            end
            if (w_handshake) begin
                r_col_index <= r_col_index + 12'd1;
                r_alpha     <= r_alpha + c_STEP;
            end
        end
    end

    assign o_ray_playerX    = r_ray_playerX;
    assign o_ray_playerY    = r_ray_playerY;
    assign o_alpha          = r_alpha;
    assign o_begin_calc     = w_begin_calc;
    assign o_col_valid      = w_col_valid;
    assign o_col_index      = r_col_index;
    assign o_col_wallX      = r_col_wallX;
    assign o_col_wallY      = r_col_wallY;
    assign o_col_wall_found = r_col_wall_found;
    assign o_col_timeout    = r_col_timeout;
    assign o_busy           = w_busy;
    assign o_frame_done     = w_frame_done;

endmodule
`default_nettype wire
